mr_lsu: RTL and testbench
=========================

MR_LSU -- requirements
Module: mr_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of cycles spent waiting for mem_ack before the access faults (1..255).
REQ-002 SHALL use `XLEN=32, `REGSEL_BITS=5, `MEM_OP_BITS=2 and `MEM_SZ_BITS=2 from the config include.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ls_valid  in  1  upstream (ALU stage) beat valid.
REQ-006 ls_ready  out  1  LSU accepts a beat this cycle.
REQ-007 ls_dest  in  XLEN  ALU result: the memory address for a load/store, or the passthrough value for NOP.
REQ-008 ls_dest_reg  in  REGSEL_BITS  destination register; 0 means no writeback.
REQ-009 ls_memop  in  MEM_OP_BITS  operation: MEM_NOP=0, MEM_LOAD=1, MEM_STORE=2; the value 3 is treated as NOP.
REQ-010 ls_size  in  MEM_SZ_BITS  access size: SZ_B=0, SZ_H=1, SZ_W=2; the value 3 is treated as SZ_W.
REQ-011 ls_signed  in  1  sign-extend the load result.
REQ-012 ls_payload  in  XLEN  store data, right-aligned.
REQ-013 mem_req  out  1  bus request, held until mem_ack.
REQ-014 mem_we  out  1  1 = write, 0 = read.
REQ-015 mem_addr  out  XLEN  word-aligned address, equal to {ls_dest[31:2], 2'b00}.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  XLEN  lane-shifted store data.
REQ-018 mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  in  XLEN  read word.
REQ-020 wb_valid, wb_data[XLEN], wb_reg[REGSEL_BITS]  out  writeback beat.
REQ-021 wb_ready  in  1  writeback accepts the beat.
REQ-022 fault  out  1  one-cycle pulse on a misaligned access or a timeout.

Function
REQ-023 SHALL implement the FSM states IDLE, BUS, WB.
REQ-024 ls_ready SHALL equal (state==IDLE) && (!wb_valid || wb_ready).
REQ-025 Accept condition: ls_valid && ls_ready.
- NOP: the beat goes straight to the writeback register with wb_data=ls_dest and wb_reg=ls_dest_reg.
- wb_valid rises on the next cycle; the FSM stays in IDLE.
REQ-026 Accept of a load or store:
- Latch the address, size, signed flag, register, payload and memop.
- Go to BUS; mem_req is asserted from the next cycle.
- Bus outputs SHALL remain stable until mem_ack.
REQ-027 Misalignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- Issue no bus request.
- Pulse fault on the cycle after accept.
- Emit no wb beat; the FSM stays in IDLE.
REQ-028 Store byte lanes:
- byte: mem_be = 1<<addr[1:0], and the byte is replicated across all lanes.
- half: mem_be = 4'b0011 << addr[1:0], and the halfword is replicated.
- word: mem_be = 4'hF.
REQ-029 Loads SHALL drive mem_be the same way as stores.
REQ-030 On mem_ack for a load:
- Shift mem_rdata right by 8*addr[1:0].
- Mask to the access size.
- Sign-extend if the signed flag is set, else zero-extend.
- Load wb_data and go to WB.
REQ-031 On mem_ack for a store: go to IDLE; a store SHALL produce no wb beat.
REQ-032 In WB, wb_valid=1; wb_valid && wb_ready returns the FSM to IDLE.
REQ-033 A load with dest_reg==0 SHALL still complete the bus access, but SHALL produce no wb beat.
REQ-034 Timeout counter:
- Cleared on entry to BUS and incremented on each BUS cycle without mem_ack.
- When it reaches TIMEOUT_CYC, deassert mem_req, pulse fault, return to IDLE, and produce no wb beat.
REQ-035 Ack arriving in the same cycle as the counter reaching TIMEOUT_CYC: the ack wins and no fault is raised.
REQ-036 NOP wb beat stalled by !wb_ready: hold wb_valid and wb_data, and hold ls_ready=0.
REQ-037 mem_ack received while in IDLE or WB SHALL be ignored.
REQ-038 Latency, measured from accept:
- NOP: wb_valid 1 cycle after accept.
- Load with ack in the first BUS cycle: wb_valid 2 cycles after accept.

Reset
REQ-039 While rst=1:
- State returns to IDLE.
- mem_req=0, mem_we=0, wb_valid=0, fault=0, mem_be=0.
- The timeout counter is cleared.
REQ-040 rst asserted mid-transaction SHALL abandon the transaction; no fault and no wb beat are produced after rst releases.
REQ-041 Data registers (wb_data, mem_addr, mem_wdata) MAY be left unreset.

Structure
REQ-042 The mem-op enum (MEM_NOP, MEM_LOAD, MEM_STORE) and the size enum (SZ_B, SZ_H, SZ_W) SHALL live in the shared package alongside e_aluops.
REQ-043 Load alignment and extension SHALL be a combinational sub-module, mr_lsu_extract: inputs rdata, offset, size and signed; output result.

Verification
REQ-044 Load word:
- Stimulus: addr 0x100, rdata 0xDEADBEEF, ack after 3 cycles.
- Response: mem_be=4'hF; wb_data=0xDEADBEEF 1 cycle after ack.
REQ-045 Byte load, signed and unsigned:
- Stimulus: addr 0x103, rdata 0x80112233.
- Signed response: wb_data=0xFFFFFF80.
- Unsigned response: wb_data=0x00000080.
REQ-046 Store halfword:
- Stimulus: addr 0x102, payload 0x0000ABCD.
- Response: mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, no wb beat.
REQ-047 Misaligned word load:
- Stimulus: load word at addr 0x101.
- Response: no mem_req, fault pulses for 1 cycle, ls_ready stays 1.
REQ-048 Timeout:
- Stimulus: TIMEOUT_CYC=4, mem_ack never asserted.
- Response: mem_req high for 4 cycles, then fault and return to IDLE.
REQ-049 Backpressure:
- Stimulus: hold wb_ready=0 for 5 cycles while loads are pending.
- Response: wb_valid and wb_data held, ls_ready=0 throughout, no beat lost or duplicated.

Source files
------------

// File: rtl/mr_lsu_pkg.sv
// mr_lsu_pkg: shared configuration and types for the load/store unit.
//   XLEN / REGSEL_BITS / MEM_OP_BITS / MEM_SZ_BITS configuration values,
//   the ALU-op, mem-op and access-size enums, and the size helper.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif
`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_SZ_BITS
`define MEM_SZ_BITS 2
`endif

package mr_lsu_pkg;

  localparam int unsigned XLEN        = `XLEN;
  localparam int unsigned REGSEL_BITS = `REGSEL_BITS;
  localparam int unsigned MEM_OP_BITS = `MEM_OP_BITS;
  localparam int unsigned MEM_SZ_BITS = `MEM_SZ_BITS;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } e_aluops;

  typedef enum logic [`MEM_OP_BITS-1:0] {
    MEM_NOP   = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } e_memop;

  typedef enum logic [`MEM_SZ_BITS-1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } e_memsz;

  // The unused size encoding 3 behaves as a word access.
  function automatic logic [`MEM_SZ_BITS-1:0] norm_size(input logic [`MEM_SZ_BITS-1:0] sz);
    return (sz == 2'd3) ? SZ_W : sz;
  endfunction

endpackage

// File: rtl/mr_lsu_extract.sv
// mr_lsu_extract: combinational load-data alignment and extension.
//   rdata     - raw bus read word
//   offset    - byte offset of the access inside the word
//   size      - access size (SZ_B / SZ_H / SZ_W, 3 = word)
//   is_signed - sign-extend instead of zero-extend
//   result    - right-aligned, extended load value
module mr_lsu_extract
  import mr_lsu_pkg::*;
(
  input  logic [XLEN-1:0]        rdata,
  input  logic [1:0]             offset,
  input  logic [MEM_SZ_BITS-1:0] size,
  input  logic                   is_signed,
  output logic [XLEN-1:0]        result
);

  logic [XLEN-1:0] shifted;

  // Shift the addressed byte lane down to bit 0, then mask/extend.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (norm_size(size))
      SZ_B:    result = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mr_lsu.sv
// mr_lsu: load/store unit between the ALU stage and a simple req/ack bus.
//   clk, rst                      - clock, synchronous active-high reset
//   ls_valid/ls_ready + ls_*      - upstream beat (address/value, reg, op, size, sign, store data)
//   mem_req/we/addr/be/wdata      - bus request, held until mem_ack
//   mem_ack/mem_rdata             - one-cycle completion with read data
//   wb_valid/wb_data/wb_reg       - writeback beat, consumed with wb_ready
//   fault                         - one-cycle pulse on misalignment or bus timeout
module mr_lsu
  import mr_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ls_valid,
  output logic                   ls_ready,
  input  logic [XLEN-1:0]        ls_dest,
  input  logic [REGSEL_BITS-1:0] ls_dest_reg,
  input  logic [MEM_OP_BITS-1:0] ls_memop,
  input  logic [MEM_SZ_BITS-1:0] ls_size,
  input  logic                   ls_signed,
  input  logic [XLEN-1:0]        ls_payload,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [3:0]             mem_be,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic                   mem_ack,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   wb_valid,
  output logic [XLEN-1:0]        wb_data,
  output logic [REGSEL_BITS-1:0] wb_reg,
  input  logic                   wb_ready,
  output logic                   fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  logic [1:0]             state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [XLEN-1:0]        mem_wdata_q, mem_wdata_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;
  logic [REGSEL_BITS-1:0] wb_reg_q, wb_reg_d;
  logic                   fault_q, fault_d;
  logic [7:0]             tmo_cnt_q, tmo_cnt_d;
  logic [1:0]             off_q, off_d;
  logic [MEM_SZ_BITS-1:0] size_q, size_d;
  logic                   signed_q, signed_d;
  logic [REGSEL_BITS-1:0] reg_q, reg_d;

  logic                   accept_c;
  logic                   is_load_c;
  logic                   is_store_c;
  logic [MEM_SZ_BITS-1:0] sz_eff_c;
  logic                   misal_c;
  logic [XLEN-1:0]        ld_result_c;

  assign ls_ready = (state_q == S_IDLE) && (!wb_valid_q || wb_ready);

  // Upstream decode; memop 3 falls through as a NOP.
  always_comb begin
    accept_c   = ls_valid && ls_ready;
    is_load_c  = (ls_memop == MEM_LOAD);
    is_store_c = (ls_memop == MEM_STORE);
    sz_eff_c   = norm_size(ls_size);
    misal_c    = ((sz_eff_c == SZ_H) && ls_dest[0]) ||
                 ((sz_eff_c == SZ_W) && (ls_dest[1:0] != 2'b00));
  end

  mr_lsu_extract u_extract (
    .rdata     (mem_rdata),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .result    (ld_result_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_reg_d    = wb_reg_q;
    fault_d     = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    signed_d    = signed_q;
    reg_d       = reg_q;

    case (state_q)
      S_IDLE: begin
        if (wb_valid_q && wb_ready) begin
          wb_valid_d = 1'b0;
        end
        if (accept_c) begin
          if (!is_load_c && !is_store_c) begin
            // NOP: pass the ALU result straight to writeback unless reg 0.
            if (ls_dest_reg != '0) begin
              wb_valid_d = 1'b1;
              wb_data_d  = ls_dest;
              wb_reg_d   = ls_dest_reg;
            end
          end else if (misal_c) begin
            fault_d = 1'b1;
          end else begin
            state_d    = S_BUS;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store_c;
            mem_addr_d = {ls_dest[XLEN-1:2], 2'b00};
            tmo_cnt_d  = '0;
            off_d      = ls_dest[1:0];
            size_d     = sz_eff_c;
            signed_d   = ls_signed;
            reg_d      = ls_dest_reg;
            // Lane enables and replicated store data; loads use the same enables.
            case (sz_eff_c)
              SZ_B: begin
                mem_be_d    = 4'b0001 << ls_dest[1:0];
                mem_wdata_d = {4{ls_payload[7:0]}};
              end
              SZ_H: begin
                mem_be_d    = 4'b0011 << ls_dest[1:0];
                mem_wdata_d = {2{ls_payload[15:0]}};
              end
              default: begin
                mem_be_d    = 4'hF;
                mem_wdata_d = ls_payload;
              end
            endcase
          end
        end
      end

      S_BUS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'h0;
          if (!mem_we_q && (reg_q != '0)) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ld_result_c;
            wb_reg_d   = reg_q;
            state_d    = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end else if (({1'b0, tmo_cnt_q} + 9'd1) == {1'b0, TMO_LIMIT}) begin
          // Ack has priority; only a cycle without ack can expire the wait.
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'h0;
          fault_d   = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      S_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'h0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      fault_q    <= 1'b0;
      tmo_cnt_q  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      reg_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      fault_q    <= fault_d;
      tmo_cnt_q  <= tmo_cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      reg_q      <= reg_d;
    end
  end

  // Data registers carry no reset.
  always_ff @(posedge clk) begin
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    wb_data_q   <= wb_data_d;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_reg    = wb_reg_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_mr_lsu.sv
// tb_mr_lsu: scoreboard bench for mr_lsu. Issued transactions push expected
// bus requests and writeback beats into queues; a bus responder and a
// writeback monitor pop and compare independently of the stimulus.
module tb_mr_lsu;
  import mr_lsu_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        rst;
  logic        ls_valid;
  logic        ls_ready;
  logic [31:0] ls_dest;
  logic [4:0]  ls_dest_reg;
  logic [1:0]  ls_memop;
  logic [1:0]  ls_size;
  logic        ls_signed;
  logic [31:0] ls_payload;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_ready;
  logic        fault;

  mr_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ls_valid    (ls_valid),
    .ls_ready    (ls_ready),
    .ls_dest     (ls_dest),
    .ls_dest_reg (ls_dest_reg),
    .ls_memop    (ls_memop),
    .ls_size     (ls_size),
    .ls_signed   (ls_signed),
    .ls_payload  (ls_payload),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_reg      (wb_reg),
    .wb_ready    (wb_ready),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_cyc;   // request cycle carrying the ack; 0 = never ack
    logic [31:0] rdata;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  int errors      = 0;
  int checks      = 0;
  int faults_seen = 0;
  int faults_exp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [4:0] rg, input logic [31:0] pay);
    ls_valid    = 1'b1;
    ls_memop    = op;
    ls_size     = sz;
    ls_signed   = sgn;
    ls_dest     = addr;
    ls_dest_reg = rg;
    ls_payload  = pay;
  endtask

  // Hold ls_valid until a cycle with ls_ready, then drop it after the accept edge.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ls_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_event({name, " accept timeout"});
    @(posedge clk);
    #1;
    ls_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] addr, input logic [4:0] rg, input logic [31:0] pay);
    drive(op, sz, sgn, addr, rg, pay);
    wait_accept("send");
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int ack_cyc, input logic [31:0] rdata);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.ack_cyc = ack_cyc; e.rdata = rdata;
    bus_q.push_back(e);
  endtask

  task automatic exp_wb(input logic [4:0] rg, input logic [31:0] data);
    wb_exp_t e;
    e.rg = rg; e.data = data;
    wb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Writeback monitor: every accepted beat must match the head of the queue.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          fail_event("unexpected wb beat");
        end else begin
          e = wb_q.pop_front();
          chk("wb_reg", 32'(wb_reg), 32'(e.rg));
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Fault monitor: counts pulses and requires them to be one cycle wide.
  initial begin
    logic fault_prev;
    fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fault && !rst) begin
        if (fault_prev) fail_event("fault wider than one cycle");
        else faults_seen++;
      end
      fault_prev = fault;
    end
  end

  // Bus responder: checks each request against the queue and acks on schedule.
  initial begin
    bus_exp_t e;
    int n;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (bus_q.size() == 0) begin
          fail_event("unexpected mem_req");
          for (int i = 0; i < 64 && mem_req; i++) @(negedge clk);
        end else begin
          e = bus_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_be", 32'(mem_be), 32'(e.be));
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          n = 1;
          while (mem_req && n <= 64) begin
            chk("bus_hold_addr", mem_addr, e.addr);
            chk("bus_hold_be", 32'(mem_be), 32'(e.be));
            if (n == e.ack_cyc) begin
              mem_ack   = 1'b1;
              mem_rdata = e.rdata;
              @(posedge clk);
              #1;
              mem_ack   = 1'b0;
              mem_rdata = 32'h0;
            end
            @(negedge clk);
            n++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit hit;
    rst = 1'b1;
    ls_valid = 1'b0; ls_dest = '0; ls_dest_reg = '0; ls_memop = '0;
    ls_size = '0; ls_signed = 1'b0; ls_payload = '0; wb_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst wb_valid", 32'(wb_valid), 0);
    chk("rst fault", 32'(fault), 0);
    chk("rst mem_be", 32'(mem_be), 0);
    chk("rst ls_ready", 32'(ls_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // NOP: one-cycle latency, memop 3 also passes through
    exp_wb(5'd3, 32'h12345678);
    send(2'd0, 2'd2, 1'b0, 32'h12345678, 5'd3, 32'h0);
    @(negedge clk);
    chk("nop latency wb_valid", 32'(wb_valid), 1);
    idle(2);
    exp_wb(5'd6, 32'h00000077);
    send(2'd3, 2'd0, 1'b0, 32'h00000077, 5'd6, 32'h0);
    idle(3);

    // Load word, ack in third bus cycle
    exp_bus(1'b0, 32'h100, 4'hF, 32'h0, 3, 32'hDEADBEEF);
    exp_wb(5'd5, 32'hDEADBEEF);
    send(2'd1, 2'd2, 1'b0, 32'h100, 5'd5, 32'h0);
    idle(8);

    // Load with ack in first bus cycle: wb_valid two cycles after accept
    exp_bus(1'b0, 32'h104, 4'hF, 32'h0, 1, 32'h12345678);
    exp_wb(5'd8, 32'h12345678);
    send(2'd1, 2'd3, 1'b0, 32'h104, 5'd8, 32'h0);
    @(negedge clk);
    chk("load latency cycle1 wb_valid", 32'(wb_valid), 0);
    @(negedge clk);
    chk("load latency cycle2 wb_valid", 32'(wb_valid), 1);
    idle(4);

    // Byte/half loads, signed and unsigned
    exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 2, 32'h80112233);
    exp_wb(5'd1, 32'hFFFFFF80);
    send(2'd1, 2'd0, 1'b1, 32'h103, 5'd1, 32'h0);
    idle(6);
    exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 1, 32'h80112233);
    exp_wb(5'd2, 32'h00000080);
    send(2'd1, 2'd0, 1'b0, 32'h103, 5'd2, 32'h0);
    idle(6);
    exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 1, 32'h80112233);
    exp_wb(5'd11, 32'hFFFF8011);
    send(2'd1, 2'd1, 1'b1, 32'h102, 5'd11, 32'h0);
    idle(6);
    exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 1, 32'h80112233);
    exp_wb(5'd12, 32'h00008011);
    send(2'd1, 2'd1, 1'b0, 32'h102, 5'd12, 32'h0);
    idle(6);
    exp_bus(1'b0, 32'h100, 4'b0010, 32'h0, 1, 32'hAABBCCDD);
    exp_wb(5'd13, 32'h000000CC);
    send(2'd1, 2'd0, 1'b0, 32'h101, 5'd13, 32'h0);
    idle(6);

    // Stores: lane enables and replication, no wb beat
    exp_bus(1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 2, 32'h0);
    send(2'd2, 2'd1, 1'b0, 32'h102, 5'd4, 32'h0000ABCD);
    idle(6);
    exp_bus(1'b1, 32'h100, 4'b0010, 32'h5A5A5A5A, 1, 32'h0);
    send(2'd2, 2'd0, 1'b0, 32'h101, 5'd4, 32'h0000005A);
    idle(6);

    // Misaligned word load and halfword load: fault, no bus request
    faults_exp++;
    send(2'd1, 2'd2, 1'b0, 32'h101, 5'd7, 32'h0);
    @(negedge clk);
    chk("misal fault", 32'(fault), 1);
    chk("misal mem_req", 32'(mem_req), 0);
    chk("misal ls_ready", 32'(ls_ready), 1);
    @(negedge clk);
    chk("misal fault drop", 32'(fault), 0);
    idle(3);
    faults_exp++;
    send(2'd1, 2'd1, 1'b0, 32'h103, 5'd7, 32'h0);
    idle(4);

    // Timeout: mem_req held for TMO cycles, then fault
    faults_exp++;
    exp_bus(1'b0, 32'h200, 4'hF, 32'h0, 0, 32'h0);
    send(2'd1, 2'd2, 1'b0, 32'h200, 5'd9, 32'h0);
    cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      if (fault) begin
        hit = 1'b1;
        break;
      end
    end
    chk("timeout req cycles", 32'(cnt), 32'(TMO));
    chk("timeout fault", 32'(hit), 1);
    chk("timeout ls_ready", 32'(ls_ready), 1);
    idle(3);

    // Ack in the last allowed cycle wins over the timeout
    exp_bus(1'b0, 32'h300, 4'hF, 32'h0, 4, 32'h0BADF00D);
    exp_wb(5'd7, 32'h0BADF00D);
    send(2'd1, 2'd2, 1'b0, 32'h300, 5'd7, 32'h0);
    idle(8);

    // Load to r0: bus access only
    exp_bus(1'b0, 32'h308, 4'hF, 32'h0, 1, 32'h55555555);
    send(2'd1, 2'd2, 1'b0, 32'h308, 5'd0, 32'h0);
    idle(6);

    // NOP held under backpressure
    wb_ready = 1'b0;
    exp_wb(5'd4, 32'hCAFE0001);
    send(2'd0, 2'd2, 1'b0, 32'hCAFE0001, 5'd4, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nop stall wb_valid", 32'(wb_valid), 1);
      chk("nop stall wb_data", wb_data, 32'hCAFE0001);
      chk("nop stall ls_ready", 32'(ls_ready), 0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    idle(3);

    // Load held under backpressure with a second load waiting
    wb_ready = 1'b0;
    exp_bus(1'b0, 32'h400, 4'hF, 32'h0, 1, 32'h11223344);
    exp_wb(5'd9, 32'h11223344);
    send(2'd1, 2'd2, 1'b0, 32'h400, 5'd9, 32'h0);
    exp_bus(1'b0, 32'h404, 4'hF, 32'h0, 2, 32'h55667788);
    exp_wb(5'd10, 32'h55667788);
    drive(2'd1, 2'd2, 1'b0, 32'h404, 5'd10, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp wb_valid", 32'(wb_valid), 1);
      chk("bp wb_data", wb_data, 32'h11223344);
      chk("bp ls_ready", 32'(ls_ready), 0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_accept("bp second load");
    idle(8);

    // Reset mid-transaction: no fault or wb beat afterwards
    exp_bus(1'b0, 32'h500, 4'hF, 32'h0, 0, 32'h0);
    send(2'd1, 2'd2, 1'b0, 32'h500, 5'd14, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post-rst fault", 32'(fault), 0);
      chk("post-rst wb_valid", 32'(wb_valid), 0);
      chk("post-rst mem_req", 32'(mem_req), 0);
    end

    idle(4);
    chk("wb queue drained", 32'(wb_q.size()), 0);
    chk("bus queue drained", 32'(bus_q.size()), 0);
    chk("fault count", 32'(faults_seen), 32'(faults_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
